// File: rtl/alarm_time_bank_pkg.sv
// alarm_pkg: shared types, constants and conversion helpers for the alarm
// time bank.
//   HOURS_PER_DAY / MINUTES_PER_HOUR : wrap points for the slot counters
//   slot_t       : one alarm setting {hours[4:0], minutes[5:0]} in binary
//   disp_hour_t  : display hour plus PM flag produced by to_12h
//   rpt_state_t  : states of the held-button auto-repeat engine
//   to_bcd2      : 0..59 binary to two BCD digits using a compare ladder
//                  (no runtime divide)
//   to_12h       : 24h binary hour to display hour for 12h or 24h mode
package alarm_pkg;

  localparam int HOURS_PER_DAY    = 24;
  localparam int MINUTES_PER_HOUR = 60;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
  } slot_t;

  typedef struct packed {
    logic [4:0] hour;
    logic       pm;
  } disp_hour_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_RATE
  } rpt_state_t;

  // The tens digit is picked by a fixed compare ladder, so the units digit
  // is a small constant subtraction rather than a divide.
  function automatic logic [7:0] to_bcd2(input logic [5:0] value);
    logic [3:0] tens;
    logic [5:0] base;
    logic [3:0] ones;
    if (value >= 6'd50) begin
      tens = 4'd5;
      base = 6'd50;
    end else if (value >= 6'd40) begin
      tens = 4'd4;
      base = 6'd40;
    end else if (value >= 6'd30) begin
      tens = 4'd3;
      base = 6'd30;
    end else if (value >= 6'd20) begin
      tens = 4'd2;
      base = 6'd20;
    end else if (value >= 6'd10) begin
      tens = 4'd1;
      base = 6'd10;
    end else begin
      tens = 4'd0;
      base = 6'd0;
    end
    ones = 4'(value - base);
    return {tens, ones};
  endfunction

  // Midnight shows as 12 AM and noon as 12 PM in 12h mode; 24h mode passes
  // the hour straight through with PM forced low.
  function automatic disp_hour_t to_12h(input logic [4:0] hour, input logic mode_24h);
    disp_hour_t result;
    result.hour = hour;
    result.pm   = 1'b0;
    if (!mode_24h) begin
      result.pm = (hour >= 5'd12);
      if (hour == 5'd0) begin
        result.hour = 5'd12;
      end else if (hour > 5'd12) begin
        result.hour = hour - 5'd12;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/alarm_time_bank_button_repeat.sv
// button_repeat: turns a debounced, held button level into one-cycle bump
// pulses. The first bump is issued on the clock after the rising edge, then
// after DELAY_CYCLES of continuous hold a bump every RATE_CYCLES until
// release.
//   clk, rst : clock and asynchronous active-high reset
//   level    : debounced button level, high while held
//   clear    : synchronous abort; returns to idle and demands a fresh
//              rising edge before the next bump
//   bump     : registered one-cycle bump pulse
module button_repeat
  import alarm_pkg::*;
#(
  parameter int DELAY_CYCLES = 500,
  parameter int RATE_CYCLES  = 100,
  parameter int CNT_W        = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clear,
  output logic bump
);

  rpt_state_t       state;
  rpt_state_t       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             bump_n;
  logic             level_q;
  logic             rise;

  assign rise = level & ~level_q;

  // The previous level keeps tracking the button even while cleared, so a
  // button that is still held when the clear drops does not look like a
  // fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RPT_IDLE;
      cnt     <= '0;
      bump    <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bump    <= bump_n;
      level_q <= level;
    end
  end

  // The counter restarts at 1 whenever a bump is issued, so reaching the
  // DELAY or RATE value marks exactly that many clocks since the last bump.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bump_n  = 1'b0;
    if (clear || !level) begin
      state_n = RPT_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (rise) begin
            state_n = RPT_DELAY;
            cnt_n   = CNT_W'(1);
            bump_n  = 1'b1;
          end
        end
        RPT_DELAY: begin
          if (cnt == CNT_W'(DELAY_CYCLES)) begin
            state_n = RPT_RATE;
            cnt_n   = CNT_W'(1);
            bump_n  = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        RPT_RATE: begin
          if (cnt == CNT_W'(RATE_CYCLES)) begin
            cnt_n  = CNT_W'(1);
            bump_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = RPT_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_time_bank.sv
// alarm_time_bank: NUM_ALARMS hour/minute alarm slots with held-button
// editing, BCD display of the selected slot, per-slot match pulses and a
// latched ringing flag.
//   i_Clk_5MHz, i_Reset         : clock, asynchronous active-high reset
//   i_Select                    : slot under edit and display
//   i_Minutes_Inc, i_Hours_Inc  : held-button levels, auto-repeat on hold
//   i_Arm_Toggle                : pulse, flips armed bit of selected slot
//   i_Dismiss                   : pulse, clears ringing (and any snooze)
//   i_Snooze                    : pulse, snooze while ringing (snooze build)
//   i_24H_Mode                  : display format select
//   i_Time_Hours/Minutes/Seconds: running time in binary
//   o_Alarm_Time                : {H tens, H units, M tens, M units} BCD
//   o_PM                        : selected slot is PM (12h mode only)
//   o_Armed, o_Match, o_Ringing : armed bits, match pulses, ringing flag
// Optional feature macro: ALARM_TIME_BANK_SNOOZE_EN enables the snooze
// logic; without it i_Snooze is accepted but ignored.
module alarm_time_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS      = 4,
  parameter int START_MINUTES   = 0,
  parameter int START_HOURS     = 0,
  parameter int CLK_HZ          = 5000000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int SNOOZE_MINUTES  = 9,
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_Clk_5MHz,
  input  logic                  i_Reset,
  input  logic [SEL_W-1:0]      i_Select,
  input  logic                  i_Minutes_Inc,
  input  logic                  i_Hours_Inc,
  input  logic                  i_Arm_Toggle,
  input  logic                  i_Dismiss,
  input  logic                  i_Snooze,
  input  logic                  i_24H_Mode,
  input  logic [4:0]            i_Time_Hours,
  input  logic [5:0]            i_Time_Minutes,
  input  logic [5:0]            i_Time_Seconds,
  output logic [15:0]           o_Alarm_Time,
  output logic                  o_PM,
  output logic [NUM_ALARMS-1:0] o_Armed,
  output logic [NUM_ALARMS-1:0] o_Match,
  output logic                  o_Ringing
);

  localparam int DELAY_CYCLES = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RATE_CYCLES  = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int CNT_MAX      = (RATE_CYCLES > DELAY_CYCLES) ? RATE_CYCLES : DELAY_CYCLES;
  localparam int CNT_W        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam slot_t START_SLOT = {5'(START_HOURS), 6'(START_MINUTES)};

  slot_t                 slots [NUM_ALARMS];
  slot_t                 sel_slot;
  disp_hour_t            disp_hour;
  logic [4:0]            hours_next;
  logic [5:0]            minutes_next;
  logic                  sel_valid;
  logic [SEL_W-1:0]      sel_q;
  logic                  sel_changed;
  logic                  hours_bump;
  logic                  minutes_bump;
  logic                  minutes_clear;
  logic [NUM_ALARMS-1:0] armed;
  logic [NUM_ALARMS-1:0] match_q;
  logic [NUM_ALARMS-1:0] match_n;
  logic [5:0]            sec_q;
  logic                  minute_boundary;
  logic                  ringing;

  assign sel_valid       = (int'(i_Select) < NUM_ALARMS);
  assign sel_changed     = (i_Select != sel_q);
  assign minutes_clear   = sel_changed | i_Hours_Inc;
  assign minute_boundary = (i_Time_Seconds == 6'd0) && (sec_q != 6'd0);

  assign o_Armed   = armed;
  assign o_Match   = match_q;
  assign o_Ringing = ringing;

  // The hours button wins over minutes by holding the minutes engine in
  // clear for as long as hours is pressed; a select change clears both so
  // a held button never spills onto the newly selected slot.
  button_repeat #(
    .DELAY_CYCLES(DELAY_CYCLES),
    .RATE_CYCLES (RATE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_minutes_repeat (
    .clk  (i_Clk_5MHz),
    .rst  (i_Reset),
    .level(i_Minutes_Inc),
    .clear(minutes_clear),
    .bump (minutes_bump)
  );

  button_repeat #(
    .DELAY_CYCLES(DELAY_CYCLES),
    .RATE_CYCLES (RATE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_hours_repeat (
    .clk  (i_Clk_5MHz),
    .rst  (i_Reset),
    .level(i_Hours_Inc),
    .clear(sel_changed),
    .bump (hours_bump)
  );

  // Selected slot, its incremented fields and the rendered display. Minutes
  // wrap without carrying into hours. An out-of-range select reads as zero.
  always_comb begin
    sel_slot = '0;
    if (sel_valid) begin
      sel_slot = slots[i_Select];
    end
    hours_next   = (sel_slot.hours >= 5'(HOURS_PER_DAY - 1)) ? 5'd0 : sel_slot.hours + 5'd1;
    minutes_next = (sel_slot.minutes >= 6'(MINUTES_PER_HOUR - 1)) ? 6'd0 : sel_slot.minutes + 6'd1;
    disp_hour    = to_12h(sel_slot.hours, i_24H_Mode);
    o_Alarm_Time = {to_bcd2({1'b0, disp_hour.hour}), to_bcd2(sel_slot.minutes)};
    o_PM         = disp_hour.pm;
  end

  // Slot storage. A bump landing on the cycle the select moves is dropped so
  // it cannot be applied to the wrong slot.
  always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
    if (i_Reset) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        slots[k] <= START_SLOT;
      end
      sel_q <= '0;
    end else begin
      sel_q <= i_Select;
      if (sel_valid && !sel_changed) begin
        if (hours_bump) begin
          slots[i_Select].hours <= hours_next;
        end
        if (minutes_bump) begin
          slots[i_Select].minutes <= minutes_next;
        end
      end
    end
  end

  // Armed bits flip on the toggle pulse for the selected slot only.
  always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
    if (i_Reset) begin
      armed <= '0;
    end else if (i_Arm_Toggle && sel_valid) begin
      armed[i_Select] <= ~armed[i_Select];
    end
  end

  // A match needs the seconds to have just rolled to zero, so holding the
  // time at hh:mm:00 or editing a slot mid-minute cannot fire again.
  always_comb begin
    match_n = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (minute_boundary && armed[k] &&
          (slots[k].hours == i_Time_Hours) && (slots[k].minutes == i_Time_Minutes)) begin
        match_n[k] = 1'b1;
      end
    end
  end

  // Seconds history and the registered match pulses.
  always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
    if (i_Reset) begin
      sec_q   <= '0;
      match_q <= '0;
    end else begin
      sec_q   <= i_Time_Seconds;
      match_q <= match_n;
    end
  end

`ifdef ALARM_TIME_BANK_SNOOZE_EN
  localparam int SNZ_W = (SNOOZE_MINUTES > 0) ? $clog2(SNOOZE_MINUTES + 1) : 1;

  logic             snooze_active;
  logic [SNZ_W-1:0] snooze_cnt;
  logic [5:0]       min_q;
  logic             minute_changed;

  assign minute_changed = (i_Time_Minutes != min_q);

  // Ringing with snooze. A fresh match outranks everything and cancels any
  // pending snooze; dismiss cancels both ringing and snooze; snooze is only
  // honoured while ringing. The countdown re-raises ringing directly,
  // without producing a match pulse.
  always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
    if (i_Reset) begin
      ringing       <= 1'b0;
      snooze_active <= 1'b0;
      snooze_cnt    <= '0;
      min_q         <= '0;
    end else begin
      min_q <= i_Time_Minutes;
      if (|match_q) begin
        ringing       <= 1'b1;
        snooze_active <= 1'b0;
      end else if (i_Dismiss) begin
        ringing       <= 1'b0;
        snooze_active <= 1'b0;
      end else if (i_Snooze && ringing) begin
        ringing       <= 1'b0;
        snooze_active <= 1'b1;
        snooze_cnt    <= SNZ_W'(SNOOZE_MINUTES);
      end else if (snooze_active && minute_changed) begin
        if (snooze_cnt <= SNZ_W'(1)) begin
          ringing       <= 1'b1;
          snooze_active <= 1'b0;
          snooze_cnt    <= '0;
        end else begin
          snooze_cnt <= snooze_cnt - SNZ_W'(1);
        end
      end
    end
  end
`else
  logic snooze_unused;

  assign snooze_unused = i_Snooze;

  // Ringing latches on any match and clears on dismiss; a match in the same
  // cycle as a dismiss keeps it set. Disarming a slot has no effect here.
  always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
    if (i_Reset) begin
      ringing <= 1'b0;
    end else if (|match_q) begin
      ringing <= 1'b1;
    end else if (i_Dismiss) begin
      ringing <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alarm_time_bank.sv
module tb_alarm_time_bank;

  localparam int NUM_ALARMS = 4;
  localparam int START_H    = 7;
  localparam int START_M    = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        min_inc;
  logic        hrs_inc;
  logic        arm_toggle;
  logic        dismiss;
  logic        snooze;
  logic        mode24;
  logic [4:0]  t_h;
  logic [5:0]  t_m;
  logic [5:0]  t_s;
  logic [15:0] alarm_time;
  logic        pm;
  logic [3:0]  armed;
  logic [3:0]  match;
  logic        ringing;

  int checks   = 0;
  int failures = 0;

  int model_h [NUM_ALARMS];
  int model_m [NUM_ALARMS];

  typedef struct packed {
    int          at_edge;
    logic [15:0] value;
  } disp_exp_t;

  typedef struct packed {
    logic [3:0] match;
    logic       ringing;
  } ring_exp_t;

  disp_exp_t disp_q [$];
  ring_exp_t ring_q [$];

  alarm_time_bank #(
    .NUM_ALARMS     (NUM_ALARMS),
    .START_MINUTES  (START_M),
    .START_HOURS    (START_H),
    .CLK_HZ         (1000),
    .REPEAT_DELAY_MS(500),
    .REPEAT_RATE_MS (100),
    .SNOOZE_MINUTES (2)
  ) dut (
    .i_Clk_5MHz    (clk),
    .i_Reset       (rst),
    .i_Select      (sel),
    .i_Minutes_Inc (min_inc),
    .i_Hours_Inc   (hrs_inc),
    .i_Arm_Toggle  (arm_toggle),
    .i_Dismiss     (dismiss),
    .i_Snooze      (snooze),
    .i_24H_Mode    (mode24),
    .i_Time_Hours  (t_h),
    .i_Time_Minutes(t_m),
    .i_Time_Seconds(t_s),
    .o_Alarm_Time  (alarm_time),
    .o_PM          (pm),
    .o_Armed       (armed),
    .o_Match       (match),
    .o_Ringing     (ringing)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_disp(input int h, input int m, input bit is24);
    int dh;
    dh = h;
    if (!is24) begin
      if (h == 0) dh = 12;
      else if (h > 12) dh = h - 12;
    end
    return 16'(((dh / 10) << 12) | ((dh % 10) << 8) | ((m / 10) << 4) | (m % 10));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_ALARMS; k++) begin
      model_h[k] = START_H;
      model_m[k] = START_M;
    end
  endtask

  task automatic set_sel(input int s);
    sel = 2'(s);
    ticks(2);
  endtask

  task automatic tap_hours(input int n);
    for (int i = 0; i < n; i++) begin
      hrs_inc = 1'b1;
      tick();
      hrs_inc = 1'b0;
      tick();
      model_h[sel] = (model_h[sel] + 1) % 24;
    end
  endtask

  task automatic tap_minutes(input int n);
    for (int i = 0; i < n; i++) begin
      min_inc = 1'b1;
      tick();
      min_inc = 1'b0;
      tick();
      model_m[sel] = (model_m[sel] + 1) % 60;
    end
  endtask

  task automatic pulse_arm();
    arm_toggle = 1'b1;
    tick();
    arm_toggle = 1'b0;
    tick();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_h = 5'(h);
    t_m = 6'(m);
    t_s = 6'(s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    min_inc = 0; hrs_inc = 0; arm_toggle = 0; dismiss = 0; snooze = 0;
    mode24 = 1'b1;
    set_time(0, 0, 0);
    model_reset();
    #12;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      sel = 2'(k);
      #1;
      checks++;
      if (alarm_time !== exp_disp(START_H, START_M, 1'b1)) begin
        failures++;
        $display("[TB] FAIL reset_slot%0d: got %h expected %h", k, alarm_time, exp_disp(START_H, START_M, 1'b1));
      end
    end
    checks++;
    if (armed !== 4'b0000 || match !== 4'b0000 || ringing !== 1'b0 || pm !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got armed=%b match=%b ringing=%b pm=%b expected 0000 0000 0 0",
               armed, match, ringing, pm);
    end
    @(negedge clk);
    rst = 1'b0;
    set_sel(0);
  endtask

  task automatic test_repeat();
    logic [15:0] last;
    disp_exp_t   e;
    set_sel(2);
    tap_hours(17);
    tap_minutes(28);
    checks++;
    if (alarm_time !== 16'h0058 || model_h[2] != 0 || model_m[2] != 58) begin
      failures++;
      $display("[TB] FAIL repeat_setup: got %h expected 0058", alarm_time);
    end
    last = alarm_time;
    disp_q.push_back('{at_edge: 2,   value: 16'h0059});
    disp_q.push_back('{at_edge: 502, value: 16'h0000});
    disp_q.push_back('{at_edge: 602, value: 16'h0001});
    min_inc = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      tick();
      if (disp_q.size() > 0 && disp_q[0].at_edge == n) begin
        e = disp_q.pop_front();
        last = e.value;
      end
      checks++;
      if (alarm_time !== last) begin
        failures++;
        $display("[TB] FAIL repeat_edge%0d: got %h expected %h", n, alarm_time, last);
      end
    end
    min_inc = 1'b0;
    ticks(3);
    model_m[2] = 1;
    checks++;
    if (alarm_time !== exp_disp(model_h[2], model_m[2], 1'b1) || disp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL repeat_after_release: got %h expected %h", alarm_time, exp_disp(model_h[2], model_m[2], 1'b1));
    end
    set_sel(0);
    checks++;
    if (alarm_time !== 16'h0730) begin
      failures++;
      $display("[TB] FAIL repeat_slot0_untouched: got %h expected 0730", alarm_time);
    end
  endtask

  task automatic test_display();
    set_sel(1);
    tap_hours(16);
    tap_minutes(35);
    mode24 = 1'b0;
    #1;
    checks++;
    if (alarm_time !== 16'h1105 || pm !== 1'b1 || alarm_time !== exp_disp(model_h[1], model_m[1], 1'b0)) begin
      failures++;
      $display("[TB] FAIL display_23_05_12h: got %h pm=%b expected 1105 pm=1", alarm_time, pm);
    end
    mode24 = 1'b1;
    tap_hours(1);
    tap_minutes(55);
    mode24 = 1'b0;
    #1;
    checks++;
    if (alarm_time !== 16'h1200 || pm !== 1'b0) begin
      failures++;
      $display("[TB] FAIL display_midnight_12h: got %h pm=%b expected 1200 pm=0", alarm_time, pm);
    end
    mode24 = 1'b1;
    #1;
    checks++;
    if (alarm_time !== 16'h0000 || pm !== 1'b0) begin
      failures++;
      $display("[TB] FAIL display_midnight_24h: got %h pm=%b expected 0000 pm=0", alarm_time, pm);
    end
  endtask

  task automatic drain_ring(input string tag);
    ring_exp_t e;
    int n;
    n = 0;
    while (ring_q.size() > 0) begin
      e = ring_q.pop_front();
      tick();
      n++;
      checks++;
      if (match !== e.match || ringing !== e.ringing) begin
        failures++;
        $display("[TB] FAIL %s_cycle%0d: got match=%b ringing=%b expected match=%b ringing=%b",
                 tag, n, match, ringing, e.match, e.ringing);
      end
    end
  endtask

  task automatic test_match();
    set_sel(3);
    tap_hours(23);
    tap_minutes(15);
    pulse_arm();
    checks++;
    if (armed !== 4'b1000 || alarm_time !== 16'h0645) begin
      failures++;
      $display("[TB] FAIL match_arm: got armed=%b time=%h expected 1000 0645", armed, alarm_time);
    end
    set_time(6, 44, 58);
    tick();
    set_time(6, 44, 59);
    ticks(2);
    set_time(6, 45, 0);
    ring_q.push_back('{match: 4'b1000, ringing: 1'b0});
    ring_q.push_back('{match: 4'b0000, ringing: 1'b1});
    for (int i = 0; i < 10; i++) ring_q.push_back('{match: 4'b0000, ringing: 1'b1});
    drain_ring("match");
  endtask

  task automatic test_dismiss();
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    checks++;
    if (ringing !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dismiss_alone: got ringing=%b expected 0", ringing);
    end
    set_sel(0);
    pulse_arm();
    checks++;
    if (armed !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL dismiss_arm0: got armed=%b expected 1001", armed);
    end
    set_time(7, 29, 59);
    tick();
    set_time(7, 30, 0);
    ring_q.push_back('{match: 4'b0001, ringing: 1'b0});
    drain_ring("dismiss_match");
    dismiss = 1'b1;
    ring_q.push_back('{match: 4'b0000, ringing: 1'b1});
    drain_ring("dismiss_coincident");
    ring_q.push_back('{match: 4'b0000, ringing: 1'b0});
    drain_ring("dismiss_after");
    dismiss = 1'b0;
  endtask

  task automatic test_hours_wins();
    min_inc = 1'b1;
    hrs_inc = 1'b1;
    ticks(3);
    model_h[0] = 8;
    hrs_inc = 1'b0;
    ticks(3);
    checks++;
    if (alarm_time !== exp_disp(model_h[0], model_m[0], 1'b1)) begin
      failures++;
      $display("[TB] FAIL hours_wins: got %h expected %h", alarm_time, exp_disp(model_h[0], model_m[0], 1'b1));
    end
    min_inc = 1'b0;
    tick();
    tap_minutes(1);
    checks++;
    if (alarm_time !== 16'h0831) begin
      failures++;
      $display("[TB] FAIL hours_wins_fresh_edge: got %h expected 0831", alarm_time);
    end
  endtask

  task automatic test_select_change();
    min_inc = 1'b1;
    ticks(2);
    model_m[0] = 32;
    sel = 2'd1;
    ticks(600);
    checks++;
    if (alarm_time !== exp_disp(model_h[1], model_m[1], 1'b1)) begin
      failures++;
      $display("[TB] FAIL select_change_new_slot: got %h expected %h", alarm_time, exp_disp(model_h[1], model_m[1], 1'b1));
    end
    min_inc = 1'b0;
    set_sel(0);
    checks++;
    if (alarm_time !== 16'h0832) begin
      failures++;
      $display("[TB] FAIL select_change_old_slot: got %h expected 0832", alarm_time);
    end
  endtask

  task automatic test_reset_mid_hold();
    hrs_inc = 1'b1;
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (alarm_time !== exp_disp(model_h[0], model_m[0], 1'b1) || armed !== 4'b0000 ||
        match !== 4'b0000 || ringing !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_hold: got time=%h armed=%b match=%b ringing=%b expected 0730 0000 0000 0",
               alarm_time, armed, match, ringing);
    end
    hrs_inc = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    set_sel(3);
    checks++;
    if (alarm_time !== 16'h0730) begin
      failures++;
      $display("[TB] FAIL reset_mid_hold_slot3: got %h expected 0730", alarm_time);
    end
  endtask

`ifdef ALARM_TIME_BANK_SNOOZE_EN
  task automatic test_snooze();
    set_sel(0);
    pulse_arm();
    set_time(7, 29, 59);
    tick();
    set_time(7, 30, 0);
    ring_q.push_back('{match: 4'b0001, ringing: 1'b0});
    ring_q.push_back('{match: 4'b0000, ringing: 1'b1});
    drain_ring("snooze_ring");
    set_time(7, 30, 10);
    snooze = 1'b1;
    ring_q.push_back('{match: 4'b0000, ringing: 1'b0});
    drain_ring("snooze_press");
    snooze = 1'b0;
    set_time(7, 31, 0);
    ring_q.push_back('{match: 4'b0000, ringing: 1'b0});
    ring_q.push_back('{match: 4'b0000, ringing: 1'b0});
    drain_ring("snooze_minute1");
    set_time(7, 32, 0);
    ring_q.push_back('{match: 4'b0000, ringing: 1'b1});
    ring_q.push_back('{match: 4'b0000, ringing: 1'b1});
    drain_ring("snooze_expire");
  endtask
`endif

  initial begin
    $display("[TB] alarm_time_bank bench start");
    sel = 2'd0;
    test_reset();
    test_repeat();
    test_display();
    test_match();
    test_dismiss();
    test_hours_wins();
    test_select_change();
    test_reset_mid_hold();
`ifdef ALARM_TIME_BANK_SNOOZE_EN
    test_snooze();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_time_bank.md
Name: alarm_time_bank

Overview:
- Multi-slot alarm store for the clock datapath.
- Holds NUM_ALARMS independent hour/minute settings in binary registers, not seconds counters, so no divide-by-60 is needed.
- Edits the selected slot with held-button auto-repeat, renders it as 4 BCD digits in 12h or 24h format, and compares every armed slot against the running time to raise match pulses and a latched ringing flag.
- Sits between the debounced button front end and the display mux and buzzer driver.

Parameters:
- NUM_ALARMS, 4: number of alarm slots (1..8).
- START_MINUTES, 0: reset minute value of every slot (0..59).
- START_HOURS, 0: reset hour value of every slot, 24h binary (0..23).
- CLK_HZ, 5000000: clock frequency, used to size the repeat timers.
- REPEAT_DELAY_MS, 500: hold time before auto-repeat starts.
- REPEAT_RATE_MS, 100: auto-repeat period.
- SNOOZE_MINUTES, 9: snooze length (snooze build only).

Ports:
- i_Clk_5MHz  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Select  in  SEL_W  slot under edit and display; SEL_W = max(1, clog2(NUM_ALARMS)).
- i_Minutes_Inc  in  1  debounced level, high while button held.
- i_Hours_Inc  in  1  debounced level, high while button held.
- i_Arm_Toggle  in  1  one-cycle pulse; toggles the armed bit of the selected slot.
- i_Dismiss  in  1  one-cycle pulse; clears ringing.
- i_Snooze  in  1  one-cycle pulse (snooze build only; ignored otherwise).
- i_24H_Mode  in  1  display format select.
- i_Time_Hours  in  5  current time hours, binary 0..23.
- i_Time_Minutes  in  6  current time minutes, binary 0..59.
- i_Time_Seconds  in  6  current time seconds, binary 0..59.
- o_Alarm_Time  out  16  {H tens, H units, M tens, M units} BCD of the selected slot.
- o_PM  out  1  selected slot is PM (12h mode only).
- o_Armed  out  NUM_ALARMS  armed bit per slot.
- o_Match  out  NUM_ALARMS  one-cycle match pulse per slot.
- o_Ringing  out  1  latched alarm-active flag.

Behaviour:
- Reset (async assert, sync release): all slots = START_HOURS:START_MINUTES; o_Armed = 0; o_Match = 0; o_Ringing = 0; repeat timers idle; snooze idle.
- Increment: a rising edge of i_Minutes_Inc or i_Hours_Inc bumps the selected slot one cycle later.
  - While held for REPEAT_DELAY_MS, further bumps occur every REPEAT_RATE_MS until release.
  - Minutes wrap 59->0 with no carry into hours. Hours wrap 23->0.
- Both buttons held: hours wins; minute inc is suppressed until the hours button is released and the minutes button sees a new rising edge.
- i_Select changes while a button is held: the repeat engine returns to idle, and no bump is applied to the new slot until a fresh rising edge.
- Arm toggle: flips o_Armed[i_Select] the next cycle.
- Match detection:
  - Register i_Time_Seconds.
  - o_Match[k] pulses for 1 cycle when the seconds sample is 0, the previous sample is nonzero, o_Armed[k]=1, and slot k equals i_Time_Hours:i_Time_Minutes.
  - Exactly one pulse per minute boundary. Editing a slot to the current minute mid-minute does not match until the next hh:mm:00.
- Ringing:
  - Set the cycle after any o_Match bit.
  - Cleared by i_Dismiss.
  - Match and dismiss in the same cycle: ringing stays set.
  - Disarming a slot does not clear ringing.
- Display is combinational from the selected slot, via a 0..59 -> BCD lookup (no runtime divide).
  - 24h: hours rendered directly; o_PM = 0.
  - 12h: 0 -> 12; 1..12 unchanged; 13..23 -> h-12. o_PM = (h >= 12).
- Widths: minutes stored in 6 bits, hours in 5 bits; repeat counter width = clog2(CLK_HZ/1000*REPEAT_DELAY_MS+1).

Optional Feature:
- Macro: ALARM_TIME_BANK_SNOOZE_EN.
- Defined:
  - i_Snooze while ringing clears o_Ringing and loads a snooze count of SNOOZE_MINUTES.
  - The count decrements on each change of i_Time_Minutes.
  - At zero, o_Ringing re-sets, with no o_Match pulse.
  - i_Dismiss cancels a pending snooze.
  - A new match during snooze sets ringing and cancels the snooze.
  - i_Snooze when not ringing is ignored.
- Undefined: i_Snooze port present but unused; no snooze logic synthesised.

Decomposition:
- Package alarm_pkg:
  - Constants HOURS_PER_DAY=24 and MINUTES_PER_HOUR=60.
  - Function to_bcd2 (0..59 -> 8-bit BCD).
  - Function to_12h (hour, mode -> display hour, pm).
  - Typedef for the slot record {hours[4:0], minutes[5:0]}.
- Sub-module button_repeat (edge detect + delay/rate timer -> one-cycle bump pulse, with sync clear input): instantiated twice.

Test Plan:
1. Reset with START 7:30, 24h mode, all slots -> o_Alarm_Time=16'h0730, o_Armed=0, o_Ringing=0.
2. CLK_HZ=1000, delay 500 ms, rate 100 ms; select slot 2 at 0:58, hold minutes 700 cycles -> bumps at cycles 1, 501, 601, giving 0:59, 0:00, 0:01 (no hour carry); slot 0 unchanged.
3. Slot 1 = 23:05, 12h mode -> 16'h1105, o_PM=1. Slot 1 = 0:00 -> 16'h1200, o_PM=0. Same slot in 24h mode -> 16'h0000.
4. Arm slot 3 = 6:45; time steps 6:44:59 -> 6:45:00 -> o_Match=4'b1000 for exactly 1 cycle, o_Ringing=1 next cycle. Held at 6:45:00 for 10 cycles -> no second pulse.
5. i_Dismiss coincident with a new match on slot 0 -> o_Ringing remains 1. Dismiss alone -> 0. Assert i_Reset mid-hold -> all state returns to reset values immediately.
6. Snooze build, SNOOZE_MINUTES=2: ring, snooze at 6:45:10 -> ringing 0; at minute change to 6:47 -> ringing 1, o_Match stays 0.
